dvi_timing_recover: RTL and testbench

Receive-side counterpart of the DVI sync generator. The block sits after the TMDS decoder, in the recovered pixel-clock domain. It takes the decoded hsync/vsync/data-enable stream and produces three kinds of output:
- per-pixel coordinates and a visible flag, in the same form the generator emits;
- measured line and frame geometry;
- a lock indication, which downstream pixel consumers use to gate themselves.

---
 rtl/dvi_timing_recover.sv | 200 ++++++++++++++++++++
 tb/tb_dvi_timing_recover.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_timing_recover.sv
// Receive-side DVI timing recovery: rebuilds pixel coordinates from the decoded
// hsync/vsync/de stream, measures line and frame geometry, and reports lock
// once that geometry has been stable for LOCK_FRAMES consecutive frames.
module dvi_timing_recover #(
    parameter int H_CNT_W     = 12,
    parameter int V_CNT_W     = 11,
    parameter int X_POS_W     = 10,
    parameter int Y_POS_W     = 9,
    parameter int LOCK_FRAMES = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               hsync_i,
    input  logic               vsync_i,
    input  logic               de_i,
    output logic [X_POS_W-1:0] pixel_x_o,
    output logic [Y_POS_W-1:0] pixel_y_o,
    output logic               visible_o,
    output logic               frame_start_o,
    output logic [H_CNT_W-1:0] h_total_o,
    output logic [H_CNT_W-1:0] h_active_o,
    output logic [V_CNT_W-1:0] v_total_o,
    output logic [V_CNT_W-1:0] v_active_o,
    output logic               locked_o
);

    localparam int                GOOD_W   = $clog2(LOCK_FRAMES + 1);
    localparam logic [H_CNT_W-1:0] H_MAX    = '1;
    localparam logic [V_CNT_W-1:0] V_MAX    = '1;
    localparam logic [GOOD_W-1:0]  GOOD_MAX = GOOD_W'(LOCK_FRAMES);

    logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic               hs_p_q, hs_p_d, vs_p_q, vs_p_d, de_p_q, de_p_d;
    logic [H_CNT_W-1:0] h_cnt_q, h_cnt_d, x_cnt_q, x_cnt_d;
    logic [V_CNT_W-1:0] v_cnt_q, v_cnt_d, y_cnt_q, y_cnt_d;
    logic [H_CNT_W-1:0] h_total_q, h_total_d, h_active_q, h_active_d;
    logic [V_CNT_W-1:0] v_total_q, v_total_d, v_active_q, v_active_d;
    logic               hmis_q, hmis_d, amis_q, amis_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic               locked_q, locked_d, armed_q, armed_d;
    logic               vis_q, vis_d, fs_q, fs_d;
    logic [X_POS_W-1:0] px_q, px_d;
    logic [Y_POS_W-1:0] py_q, py_d;

    logic               line_ev, frame_ev, de_fall, h_sat, v_sat;
    logic               h_mis_now, a_mis_now, frame_ok;
    logic [H_CNT_W-1:0] h_meas;

    // Edge detection, geometry counters, stability tracking and pixel outputs.
    always_comb begin
        hs_d   = hsync_i;
        vs_d   = vsync_i;
        de_d   = de_i;
        hs_p_d = hs_q;
        vs_p_d = vs_q;
        de_p_d = de_q;

        line_ev   = hs_p_q & ~hs_q;
        frame_ev  = vs_p_q & ~vs_q;
        de_fall   = de_p_q & ~de_q;
        h_sat     = (h_cnt_q == H_MAX);
        v_sat     = (v_cnt_q == V_MAX);
        h_meas    = h_cnt_q + 1'b1;
        h_mis_now = line_ev && (h_meas != h_total_q);
        a_mis_now = de_fall && (x_cnt_q != h_active_q);
        frame_ok  = !hmis_q && !amis_q && (v_cnt_q == v_total_q) && (y_cnt_q == v_active_q);

        h_cnt_d   = h_cnt_q;
        h_total_d = h_total_q;
        if (line_ev) begin
            h_cnt_d   = '0;
            h_total_d = h_meas;
        end else if (!h_sat) begin
            h_cnt_d = h_cnt_q + 1'b1;
        end else begin
            h_total_d = '0;
        end

        // A line event coinciding with a frame event opens the new frame.
        v_cnt_d    = v_cnt_q;
        v_total_d  = v_total_q;
        v_active_d = v_active_q;
        if (line_ev && !v_sat) begin
            v_cnt_d = v_cnt_q + 1'b1;
        end
        if (frame_ev) begin
            v_total_d  = v_cnt_q;
            v_active_d = y_cnt_q;
            v_cnt_d    = line_ev ? V_CNT_W'(1) : '0;
        end else if (v_sat) begin
            v_total_d = '0;
        end

        x_cnt_d = '0;
        if (de_q) begin
            x_cnt_d = (x_cnt_q == H_MAX) ? x_cnt_q : x_cnt_q + 1'b1;
        end
        y_cnt_d    = y_cnt_q;
        h_active_d = h_active_q;
        if (de_fall) begin
            h_active_d = x_cnt_q;
            if (y_cnt_q != V_MAX) begin
                y_cnt_d = y_cnt_q + 1'b1;
            end
        end
        if (frame_ev) begin
            y_cnt_d = '0;
        end

        // Mismatches seen in the frame-event cycle belong to the new frame.
        hmis_d = frame_ev ? h_mis_now : (hmis_q | h_mis_now);
        amis_d = frame_ev ? a_mis_now : (amis_q | a_mis_now);

        good_d   = good_q;
        locked_d = locked_q;
        if (frame_ev) begin
            if (!frame_ok) begin
                good_d = '0;
            end else if (good_q != GOOD_MAX) begin
                good_d = good_q + 1'b1;
            end
            locked_d = (good_d == GOOD_MAX);
        end
        if (h_sat || v_sat) begin
            good_d   = '0;
            locked_d = 1'b0;
        end

        // frame_start is held off until a real frame boundary has been seen.
        armed_d = armed_q | frame_ev;
        vis_d   = de_q;
        px_d    = de_q ? x_cnt_q[X_POS_W-1:0] : '0;
        py_d    = de_q ? y_cnt_q[Y_POS_W-1:0] : '0;
        fs_d    = de_q && armed_q && (x_cnt_q == '0) && (y_cnt_q == '0);
    end

    // State register; sync inputs reset to their idle level so no edge follows reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            de_q       <= 1'b0;
            hs_p_q     <= 1'b1;
            vs_p_q     <= 1'b1;
            de_p_q     <= 1'b0;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            x_cnt_q    <= '0;
            y_cnt_q    <= '0;
            h_total_q  <= '0;
            h_active_q <= '0;
            v_total_q  <= '0;
            v_active_q <= '0;
            hmis_q     <= 1'b0;
            amis_q     <= 1'b0;
            good_q     <= '0;
            locked_q   <= 1'b0;
            armed_q    <= 1'b0;
            vis_q      <= 1'b0;
            fs_q       <= 1'b0;
            px_q       <= '0;
            py_q       <= '0;
        end else begin
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            de_q       <= de_d;
            hs_p_q     <= hs_p_d;
            vs_p_q     <= vs_p_d;
            de_p_q     <= de_p_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            x_cnt_q    <= x_cnt_d;
            y_cnt_q    <= y_cnt_d;
            h_total_q  <= h_total_d;
            h_active_q <= h_active_d;
            v_total_q  <= v_total_d;
            v_active_q <= v_active_d;
            hmis_q     <= hmis_d;
            amis_q     <= amis_d;
            good_q     <= good_d;
            locked_q   <= locked_d;
            armed_q    <= armed_d;
            vis_q      <= vis_d;
            fs_q       <= fs_d;
            px_q       <= px_d;
            py_q       <= py_d;
        end
    end

    assign pixel_x_o     = px_q;
    assign pixel_y_o     = py_q;
    assign visible_o     = vis_q;
    assign frame_start_o = fs_q;
    assign h_total_o     = h_total_q;
    assign h_active_o    = h_active_q;
    assign v_total_o     = v_total_q;
    assign v_active_o    = v_active_q;
    assign locked_o      = locked_q;

endmodule

// File: tb/tb_dvi_timing_recover.sv
// Bench for dvi_timing_recover: drives a small raster from a position model,
// scoreboards the pixel outputs and spot-checks geometry and lock behaviour.
module tb_dvi_timing_recover;

    // Reduced raster keeps the run short; widths stay at their defaults.
    localparam int H_ACT = 32;
    localparam int HS_S  = 34;
    localparam int HS_E  = 38;
    localparam int H_TOT = 40;
    localparam int V_ACT = 24;
    localparam int VS_S  = 26;
    localparam int VS_E  = 28;
    localparam int V_TOT = 30;
    localparam int FRAME = H_TOT * V_TOT;

    logic        clk, rst_n, hsync, vsync, de;
    logic [9:0]  pixel_x;
    logic [8:0]  pixel_y;
    logic        visible, frame_start, locked;
    logic [11:0] h_total, h_active;
    logic [10:0] v_total, v_active;

    dvi_timing_recover dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .hsync_i      (hsync),
        .vsync_i      (vsync),
        .de_i         (de),
        .pixel_x_o    (pixel_x),
        .pixel_y_o    (pixel_y),
        .visible_o    (visible),
        .frame_start_o(frame_start),
        .h_total_o    (h_total),
        .h_active_o   (h_active),
        .v_total_o    (v_total),
        .v_active_o   (v_active),
        .locked_o     (locked)
    );

    typedef struct {
        logic vis;
        int   x;
        int   y;
        logic fs;
        bit   ychk;
    } px_t;

    px_t  sb[$];
    px_t  ce;
    int   n_checks = 0;
    int   n_errors = 0;
    int   h, v, vs_h, short_v, vs_falls;
    bit   hold, armed;
    logic vs_prev;
    int   exp_fs_cnt = 0;
    int   dut_fs_cnt = 0;
    int   last_px_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One pixel clock of stimulus; pushes the expected output for that pixel.
    task automatic drive();
        int   pos;
        logic hs_n, vs_n, de_n;
        px_t  e;
        @(posedge clk);
        #1;
        pos  = v * H_TOT + h;
        hs_n = !(h >= HS_S && h < HS_E);
        vs_n = !(pos >= VS_S * H_TOT + vs_h && pos < VS_E * H_TOT + vs_h);
        de_n = (h < H_ACT) && (v < V_ACT);
        if (hold) begin
            hs_n = 1'b1;
            vs_n = 1'b1;
            de_n = 1'b0;
        end
        hsync = hs_n;
        vsync = vs_n;
        de    = de_n;
        if (vs_prev && !vs_n) begin
            vs_falls++;
            armed = 1'b1;
        end
        vs_prev = vs_n;
        if (rst_n) begin
            e.vis  = de_n;
            e.x    = de_n ? h : 0;
            e.y    = de_n ? v : 0;
            e.fs   = de_n && armed && h == 0 && v == 0;
            e.ychk = armed;
            sb.push_back(e);
        end
        h++;
        if (h > ((v == short_v) ? H_TOT - 2 : H_TOT - 1)) begin
            h = 0;
            if (v == short_v) short_v = -1;
            v = (v == V_TOT - 1) ? 0 : v + 1;
        end
    endtask

    task automatic run_to(input int tv, input int th);
        int guard = 0;
        while (!(v == tv && h == th) && guard < 2 * FRAME) begin
            drive();
            guard++;
        end
        chk("run_to_bound", (v == tv && h == th), 1);
    endtask

    task automatic run_falls(input int n);
        int target = vs_falls + n;
        int guard  = 0;
        while (vs_falls < target && guard < (n + 1) * FRAME) begin
            drive();
            guard++;
        end
        chk("vsync_wait", vs_falls, target);
    endtask

    // Outputs for a pixel appear two clocks after it is driven.
    always @(negedge clk) begin
        if (frame_start === 1'b1) dut_fs_cnt++;
        if (sb.size() >= 3) begin
            ce = sb.pop_front();
            chk("visible", visible, ce.vis);
            chk("pixel_x", pixel_x, ce.x);
            if (ce.ychk) chk("pixel_y", pixel_y, ce.y);
            chk("frame_start", frame_start, ce.fs);
            if (ce.fs) exp_fs_cnt++;
            if (ce.vis && ce.ychk && ce.x == H_ACT - 1 && ce.y == V_ACT - 1) last_px_seen++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        h = 0; v = 0; vs_h = 0; short_v = -1; vs_falls = 0;
        hold = 1'b0; armed = 1'b0; vs_prev = 1'b1;
        hsync = 1'b1; vsync = 1'b1; de = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("rst_locked", locked, 0);
        chk("rst_visible", visible, 0);
        chk("rst_h_total", h_total, 0);
        chk("rst_v_total", v_total, 0);
        #21;
        rst_n = 1'b1;

        // Clean lock
        run_falls(3); drive(); drive();
        chk("lock_f3", locked, 0);
        run_falls(1); drive();
        chk("lock_f4_early", locked, 0);
        drive();
        chk("lock_f4", locked, 1);
        chk("h_total", h_total, H_TOT);
        chk("h_active", h_active, H_ACT);
        chk("v_total", v_total, V_TOT);
        chk("v_active", v_active, V_ACT);

        // Glitch: line 5 is one clock short
        run_to(0, 0);
        short_v = 5;
        run_to(6, HS_S); drive(); drive(); drive();
        chk("glitch_h_total", h_total, H_TOT - 1);
        chk("glitch_still_locked", locked, 1);
        run_to(7, HS_S); drive(); drive(); drive();
        chk("glitch_h_recover", h_total, H_TOT);
        run_falls(1); drive(); drive();
        chk("glitch_unlock", locked, 0);
        run_falls(1); drive(); drive();
        chk("glitch_relock_f1", locked, 0);
        run_falls(1); drive(); drive();
        chk("glitch_relock_f2", locked, 1);

        // Signal loss: last hsync fall at (1,HS_S); six drives made by (2,0)
        run_to(2, 0);
        hold  = 1'b1;
        armed = 1'b0;
        repeat (4092) drive();
        chk("loss_pre_locked", locked, 1);
        chk("loss_pre_h_total", h_total, H_TOT);
        drive();
        chk("loss_locked", locked, 0);
        chk("loss_h_total", h_total, 0);
        run_to(0, 0);
        hold = 1'b0;
        run_falls(3); drive(); drive();
        chk("loss_relock_f3", locked, 0);
        run_falls(1); drive(); drive();
        chk("loss_relock_f4", locked, 1);
        chk("loss_h_total_back", h_total, H_TOT);

        // Simultaneous hsync/vsync falls
        run_to(0, 0);
        vs_h = HS_S;
        run_falls(1); drive(); drive();
        chk("sim_locked_1", locked, 1);
        chk("sim_v_total_1", v_total, V_TOT);
        run_falls(1); drive(); drive();
        chk("sim_locked_2", locked, 1);
        chk("sim_v_total_2", v_total, V_TOT);

        // Mid-frame reset during a visible pixel
        run_to(10, 10);
        drive();
        chk("pre_rst_visible", visible, 1);
        chk("pre_rst_locked", locked, 1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        armed    = 1'b0;
        vs_falls = 0;
        #1;
        chk("mrst_visible", visible, 0);
        chk("mrst_pixel_x", pixel_x, 0);
        chk("mrst_pixel_y", pixel_y, 0);
        chk("mrst_frame_start", frame_start, 0);
        chk("mrst_h_total", h_total, 0);
        chk("mrst_h_active", h_active, 0);
        chk("mrst_v_total", v_total, 0);
        chk("mrst_v_active", v_active, 0);
        chk("mrst_locked", locked, 0);
        run_to(10, 36);
        rst_n = 1'b1;
        run_falls(3); drive(); drive();
        chk("mrst_lock_f3", locked, 0);
        run_falls(1); drive(); drive();
        chk("mrst_lock_f4", locked, 1);

        chk("frame_start_count", dut_fs_cnt, exp_fs_cnt);
        chk("last_pixel_seen", (last_px_seen > 0), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
